// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and counter sizing helper.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The iteration counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Request/result bundle for the sequential restoring divider.
// The requester uses the master view and the divider uses the slave view.
interface seq_restoring_divider_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_restoring_divider_trial_sub.sv
// Trial subtraction stage: computes a + ~b + cin with carry-out.
// With cin tied high, cout = 1 means a >= b (no borrow).
module trial_sub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             cout_o
);

  assign {cout_o, diff_o} = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider producing one quotient bit per clock.
// Defining SEQ_RESTORING_DIVIDER_SIGNED_EN makes operands two's complement.
module seq_restoring_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  seq_restoring_divider_if.slave bus
);

  localparam int CntW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] partRem_q, partRem_d;
  logic [WIDTH-1:0] shiftQ_q, shiftQ_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             divByZero_q, divByZero_d;

  logic [WIDTH-1:0] trialA;
  logic [WIDTH-1:0] trialDiff;
  logic             trialCarry;
  logic [WIDTH-1:0] nextQ;
  logic [WIDTH-1:0] nextR;
  logic [WIDTH-1:0] dividendMag;
  logic [WIDTH-1:0] divisorMag;
  logic [WIDTH-1:0] finalQ;
  logic [WIDTH-1:0] finalR;

  assign trialA = {partRem_q[WIDTH-2:0], shiftQ_q[WIDTH-1]};

  trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
    .a_i    (trialA),
    .b_i    (divisor_q),
    .cin_i  (1'b1),
    .diff_o (trialDiff),
    .cout_o (trialCarry)
  );

  assign nextQ = {shiftQ_q[WIDTH-2:0], trialCarry};
  assign nextR = trialCarry ? trialDiff : trialA;

`ifdef SEQ_RESTORING_DIVIDER_SIGNED_EN
  logic negQuot_q, negQuot_d;
  logic negRem_q, negRem_d;

  // Divide magnitudes, then restore signs so the result truncates toward zero.
  assign dividendMag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign divisorMag  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
  assign finalQ      = negQuot_q ? -nextQ : nextQ;
  assign finalR      = negRem_q  ? -nextR : nextR;

  always_comb begin
    negQuot_d = negQuot_q;
    negRem_d  = negRem_q;
    if (state_q == IDLE && bus.start) begin
      negQuot_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      negRem_d  = bus.dividend[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
    end else begin
      negQuot_q <= negQuot_d;
      negRem_q  <= negRem_d;
    end
  end
`else
  assign dividendMag = bus.dividend;
  assign divisorMag  = bus.divisor;
  assign finalQ      = nextQ;
  assign finalR      = nextR;
`endif

  always_comb begin
    state_d     = state_q;
    partRem_d   = partRem_q;
    shiftQ_d    = shiftQ_q;
    divisor_d   = divisor_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    divByZero_d = divByZero_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = bus.dividend;
            divByZero_d = 1'b1;
          end else begin
            state_d     = RUN;
            partRem_d   = '0;
            shiftQ_d    = dividendMag;
            divisor_d   = divisorMag;
            count_d     = '0;
            divByZero_d = 1'b0;
          end
        end
      end
      RUN: begin
        partRem_d = nextR;
        shiftQ_d  = nextQ;
        count_d   = count_q + CntW'(1);
        if (count_q == CntW'(WIDTH - 1)) begin
          state_d     = DONE;
          quotient_d  = finalQ;
          remainder_d = finalR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      partRem_q   <= '0;
      shiftQ_q    <= '0;
      divisor_q   <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divByZero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      partRem_q   <= partRem_d;
      shiftQ_q    <= shiftQ_d;
      divisor_q   <= divisor_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divByZero_q <= divByZero_d;
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = divByZero_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (WIDTH=4); expected results are
// hand-computed, with signed variants when SEQ_RESTORING_DIVIDER_SIGNED_EN is set.
module tb_seq_restoring_divider;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  seq_restoring_divider_if #(.WIDTH(4)) bus ();

  seq_restoring_divider #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEQ_RESTORING_DIVIDER_SIGNED_EN
  localparam logic [3:0] Q13d3 = 4'hF, R13d3 = 4'h0;
  localparam logic [3:0] Q15d1 = 4'hF, R15d1 = 4'h0;
  localparam logic [3:0] Q7d9  = 4'hF, R7d9  = 4'h0;
  localparam logic [3:0] Q8d2  = 4'hC, R8d2  = 4'h0;
  localparam logic [3:0] Q14d5 = 4'h0, R14d5 = 4'hE;
`else
  localparam logic [3:0] Q13d3 = 4'd4,  R13d3 = 4'd1;
  localparam logic [3:0] Q15d1 = 4'd15, R15d1 = 4'd0;
  localparam logic [3:0] Q7d9  = 4'd0,  R7d9  = 4'd7;
  localparam logic [3:0] Q8d2  = 4'd4,  R8d2  = 4'd0;
  localparam logic [3:0] Q14d5 = 4'd2,  R14d5 = 4'd4;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request at a falling edge and release start just after the accepting edge.
  task automatic applyStimulus(input logic [3:0] dvd, input logic [3:0] dvs);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen; -1 on timeout.
  // injectAt >= 0 raises a stray 2/1 start request on that falling edge.
  task automatic waitDone(input int injectAt, output int cycles, output int busyGaps);
    cycles   = 0;
    busyGaps = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == injectAt) begin
        bus.start    = 1'b1;
        bus.dividend = 4'd2;
        bus.divisor  = 4'd1;
      end else if (i == injectAt + 1) begin
        bus.start = 1'b0;
      end
      if (bus.done) return;
      if (!bus.busy) busyGaps++;
      cycles++;
    end
    cycles = -1;
  endtask

  task automatic checkResult(input string tag, input int lat, input int gaps, input int expLat,
                             input logic [3:0] expQ, input logic [3:0] expR, input logic expDbz);
    checkOutput({tag, ".latency"}, lat, expLat);
    checkOutput({tag, ".busyGaps"}, gaps, 0);
    checkOutput({tag, ".busyAtDone"}, 32'(bus.busy), 0);
    checkOutput({tag, ".quotient"}, 32'(bus.quotient), 32'(expQ));
    checkOutput({tag, ".remainder"}, 32'(bus.remainder), 32'(expR));
    checkOutput({tag, ".divByZero"}, 32'(bus.div_by_zero), 32'(expDbz));
  endtask

  task automatic runDivision(input string tag, input logic [3:0] dvd, input logic [3:0] dvs,
                             input int expLat, input logic [3:0] expQ, input logic [3:0] expR,
                             input logic expDbz);
    int lat;
    int gaps;
    applyStimulus(dvd, dvs);
    waitDone(-1, lat, gaps);
    checkResult(tag, lat, gaps, expLat, expQ, expR, expDbz);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int gaps;
    int doneSeen;
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.busy", 32'(bus.busy), 0);
    checkOutput("reset.done", 32'(bus.done), 0);
    checkOutput("reset.quotient", 32'(bus.quotient), 0);
    checkOutput("reset.remainder", 32'(bus.remainder), 0);
    checkOutput("reset.divByZero", 32'(bus.div_by_zero), 0);
    rst = 1'b0;

    runDivision("div13by3", 4'd13, 4'd3, 4, Q13d3, R13d3, 1'b0);
    @(negedge clk);
    checkOutput("div13by3.donePulse", 32'(bus.done), 0);

    runDivision("div15by1", 4'd15, 4'd1, 4, Q15d1, R15d1, 1'b0);

    // Request held during DONE must wait for IDLE before being accepted.
    bus.start    = 1'b1;
    bus.dividend = 4'd7;
    bus.divisor  = 4'd9;
    @(posedge clk);
    #1 checkOutput("backToBack.notInDone", 32'(bus.busy), 0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    checkOutput("backToBack.accepted", 32'(bus.busy), 1);
    waitDone(-1, lat, gaps);
    checkResult("div7by9", lat, gaps, 4, Q7d9, R7d9, 1'b0);

    runDivision("div9by0", 4'd9, 4'd0, 0, 4'hF, 4'd9, 1'b1);
    runDivision("div8by2", 4'd8, 4'd2, 4, Q8d2, R8d2, 1'b0);

    applyStimulus(4'd13, 4'd3);
    waitDone(2, lat, gaps);
    checkResult("ignoredStart", lat, gaps, 4, Q13d3, R13d3, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("ignoredStart.notQueued", 32'(bus.busy), 0);
    checkOutput("ignoredStart.held", 32'(bus.quotient), 32'(Q13d3));

    applyStimulus(4'd14, 4'd5);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midReset.busy", 32'(bus.busy), 0);
    checkOutput("midReset.done", 32'(bus.done), 0);
    checkOutput("midReset.quotient", 32'(bus.quotient), 0);
    checkOutput("midReset.remainder", 32'(bus.remainder), 0);
    rst = 1'b0;
    doneSeen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) doneSeen++;
    end
    checkOutput("midReset.noDone", doneSeen, 0);
    runDivision("div14by5", 4'd14, 4'd5, 4, Q14d5, R14d5, 1'b0);

`ifdef SEQ_RESTORING_DIVIDER_SIGNED_EN
    runDivision("negSeven.by2", 4'b1001, 4'b0010, 4, 4'b1101, 4'b1111, 1'b0);
    runDivision("seven.byNeg2", 4'b0111, 4'b1110, 4, 4'b1101, 4'b0001, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
